// File: rtl/alu_seq.sv
// Registered, handshaked Hack ALU with carry/overflow flags and an optional
// multi-cycle shift-add multiply mode.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  // state | meaning
  // IDLE  | accepting ops; hack ops complete on the accepting edge
  // MUL   | shift-add multiply in progress, one partial product per edge
  typedef enum logic {IDLE, MUL} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             no_q, no_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] xp, yp, hack_pre, hack_r, acc_sum, mul_r;
  logic [WIDTH:0]   sum;
  logic             hack_cy, hack_ov, mul_sel, accept;

  always_comb begin
    xp = zx ? '0 : x;
    if (nx) xp = ~xp;
    yp = zy ? '0 : y;
    if (ny) yp = ~yp;
  end

  assign sum      = {1'b0, xp} + {1'b0, yp};
  assign hack_pre = f ? sum[WIDTH-1:0] : (xp & yp);
  assign hack_r   = no ? ~hack_pre : hack_pre;
  assign hack_cy  = f & sum[WIDTH];
  assign hack_ov  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);

  // Low half of the product is sign-agnostic, so a plain unsigned shift-add suffices.
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_r    = no_q ? ~acc_sum : acc_sum;

  assign mul_sel  = (MUL_EN != 0) && mul;
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    no_d        = no_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    cy_d        = cy_q;
    ov_d        = ov_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul_sel) begin
            mcand_d     = xp;
            mplier_d    = yp;
            no_d        = no;
            acc_d       = '0;
            count_d     = CW'(WIDTH - 1);
            state_d     = MUL;
            out_valid_d = 1'b0;
          end else begin
            out_d       = hack_r;
            zr_d        = ~|hack_r;
            ng_d        = hack_r[WIDTH-1];
            cy_d        = hack_cy;
            ov_d        = hack_ov;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        if (count_q == '0) begin
          out_d       = mul_r;
          zr_d        = ~|mul_r;
          ng_d        = mul_r[WIDTH-1];
          cy_d        = 1'b0;
          ov_d        = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      no_q        <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      no_q        <= no_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 16-bit instance with multiply and an
// 8-bit instance with multiply disabled, sharing clock and reset.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam logic [5:0] C_AND  = 6'b000000;
  localparam logic [5:0] C_NO   = 6'b000001;
  localparam logic [5:0] C_ADD  = 6'b000010;
  localparam logic [5:0] C_SUB  = 6'b010011;

  logic        a_in_valid, a_in_ready, a_mul, a_out_valid, a_out_ready;
  logic        a_zr, a_ng, a_cy, a_ov;
  logic [15:0] a_x, a_y, a_out;
  logic [5:0]  a_c;
  logic        b_in_valid, b_in_ready, b_mul, b_out_valid, b_out_ready;
  logic        b_zr, b_ng, b_cy, b_ov;
  logic [7:0]  b_x, b_y, b_out;
  logic [5:0]  b_c;

  logic [19:0] a_obs, b_obs;
  assign a_obs = {a_out, a_zr, a_ng, a_cy, a_ov};
  assign b_obs = {8'h00, b_out, b_zr, b_ng, b_cy, b_ov};

  alu_seq #(.WIDTH(16), .MUL_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .zx(a_c[5]), .nx(a_c[4]), .zy(a_c[3]), .ny(a_c[2]),
    .f(a_c[1]), .no(a_c[0]), .mul(a_mul), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out(a_out), .zr(a_zr), .ng(a_ng), .cy(a_cy), .ov(a_ov)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .zx(b_c[5]), .nx(b_c[4]), .zy(b_c[3]), .ny(b_c[2]),
    .f(b_c[1]), .no(b_c[0]), .mul(b_mul), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out(b_out), .zr(b_zr), .ng(b_ng), .cy(b_cy), .ov(b_ov)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] qa[$];
  logic [19:0] qb[$];

  // Reference: {result[15:0], zr, ng, cy, ov} for a w-bit ALU.
  function automatic logic [19:0] model(input int w, input logic [15:0] x,
                                        input logic [15:0] y, input logic [5:0] c,
                                        input logic m);
    longint unsigned mask, xp, yp, s, r;
    logic cyv, ovv, xm, ym, rm;
    mask = (64'd1 << w) - 64'd1;
    xp = c[5] ? 64'd0 : (64'(x) & mask);
    if (c[4]) xp = ~xp & mask;
    yp = c[3] ? 64'd0 : (64'(y) & mask);
    if (c[2]) yp = ~yp & mask;
    s = xp + yp;
    cyv = 1'b0;
    ovv = 1'b0;
    if (m) begin
      r = (xp * yp) & mask;
    end else if (c[1]) begin
      r   = s & mask;
      cyv = ((s >> w) & 64'd1) != 0;
      xm  = ((xp >> (w - 1)) & 64'd1) != 0;
      ym  = ((yp >> (w - 1)) & 64'd1) != 0;
      rm  = ((r >> (w - 1)) & 64'd1) != 0;
      ovv = (xm == ym) && (rm != xm);
    end else begin
      r = xp & yp;
    end
    if (c[0]) r = ~r & mask;
    return {r[15:0], r == 0, ((r >> (w - 1)) & 64'd1) != 0, cyv, ovv};
  endfunction

  function automatic logic [19:0] pop_a();
    if (qa.size() == 0) return 'x;
    return qa.pop_front();
  endfunction

  function automatic logic [19:0] pop_b();
    if (qb.size() == 0) return 'x;
    return qb.pop_front();
  endfunction

  task automatic set_a(input logic [15:0] x, input logic [15:0] y,
                       input logic [5:0] c, input logic m);
    a_in_valid = 1'b1; a_x = x; a_y = y; a_c = c; a_mul = m;
  endtask

  task automatic set_b(input logic [7:0] x, input logic [7:0] y,
                       input logic [5:0] c, input logic m);
    b_in_valid = 1'b1; b_x = x; b_y = y; b_c = c; b_mul = m;
  endtask

  // One clock: record accepts into the scoreboards, then step to 1 unit past the edge.
  task automatic cyc();
    #1;
    if (a_in_valid && a_in_ready) qa.push_back(model(16, a_x, a_y, a_c, a_mul));
    if (b_in_valid && b_in_ready) qb.push_back(model(8, {8'h00, b_x}, {8'h00, b_y}, b_c, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    vectors++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_initial_ready: got %b expected 11", {a_in_ready, b_in_ready});
    end
    set_a(16'd5, 16'd3, C_ADD, 1'b0);
    cyc();
    a_in_valid = 1'b0;
    e = pop_a();
    vectors++;
    if ({a_out_valid, a_obs} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL reset_pre_op: got %h expected %h", {a_out_valid, a_obs}, {1'b1, e});
    end
    set_a(16'd9, 16'd9, C_ADD, 1'b0);
    set_b(8'd4, 8'd4, C_ADD, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_out_valid, a_in_ready, a_obs, b_out_valid, b_in_ready, b_obs} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0",
               {a_out_valid, a_in_ready, a_obs, b_out_valid, b_in_ready, b_obs});
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({a_in_ready, b_in_ready, a_out_valid, b_out_valid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 1100",
               {a_in_ready, b_in_ready, a_out_valid, b_out_valid});
    end
  endtask

  task automatic test_hack_b2b();
    logic [15:0] tx[4] = '{16'd5, 16'd3, 16'h7FFF, 16'hFFFF};
    logic [15:0] ty[4] = '{16'd3, 16'd5, 16'd1, 16'd1};
    logic [5:0]  tc[4] = '{C_ADD, C_SUB, C_ADD, C_ADD};
    logic [19:0] e;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(tx[i], ty[i], tc[i], 1'b0);
      cyc();
      e = pop_a();
      vectors++;
      if ({a_out_valid, a_obs} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL hack_op%0d: got %h expected %h", i, {a_out_valid, a_obs}, {1'b1, e});
      end
    end
    a_in_valid = 1'b0;
    cyc();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hack_drain: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] e1, e;
    a_out_ready = 1'b0;
    set_a(16'd10, 16'd20, C_ADD, 1'b0);
    cyc();
    e1 = (qa.size() == 1) ? qa[0] : 'x;
    set_a(16'h00F0, 16'h0FF0, C_AND, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_obs !== e1 || qa.size() != 1) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got rdy=%b vld=%b res=%h q=%0d expected rdy=0 vld=1 res=%h q=1",
                 k, a_in_ready, a_out_valid, a_obs, qa.size(), e1);
      end
    end
    a_out_ready = 1'b1;
    #1;
    vectors++;
    if (a_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_release: got %b expected 1", a_in_ready);
    end
    cyc();
    e = pop_a();
    e = pop_a();
    vectors++;
    if ({a_out_valid, a_obs} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL bp_second: got %h expected %h", {a_out_valid, a_obs}, {1'b1, e});
    end
    a_in_valid = 1'b0;
    cyc();
    vectors++;
    if (a_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got out_valid=%b expected 0", a_out_valid);
    end
  endtask

  task automatic test_mul();
    logic [15:0] mx[4] = '{16'd300, 16'h0100, 16'hFFFF, 16'd6};
    logic [15:0] my[4] = '{16'd7, 16'h0100, 16'd3, 16'd7};
    logic [5:0]  mc[4] = '{C_AND, C_AND, C_ADD, C_NO};
    logic [19:0] e;
    int n;
    logic hi;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(mx[i], my[i], mc[i], 1'b1);
      cyc();
      a_in_valid = 1'b0;
      a_x = 16'($urandom);
      a_y = 16'($urandom);
      a_c = 6'($urandom);
      a_mul = 1'($urandom);
      n = 0;
      hi = 1'b0;
      while (a_out_valid !== 1'b1 && n < 40) begin
        if (a_in_ready !== 1'b0) hi = 1'b1;
        cyc();
        n++;
      end
      e = pop_a();
      vectors++;
      if (n != 16 || hi !== 1'b0 || a_obs !== e) begin
        miscompares++;
        $display("FAIL mul%0d: got edges=%0d rdy_high=%b res=%h expected edges=16 rdy_high=0 res=%h",
                 i, n, hi, a_obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [19:0] e;
    int n;
    logic spur;
    a_out_ready = 1'b1;
    set_a(16'd5, 16'd5, C_AND, 1'b1);
    cyc();
    a_in_valid = 1'b0;
    repeat (8) cyc();
    #1;
    rst_n = 1'b0;
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (a_out_valid !== 1'b0) spur = 1'b1;
      cyc();
    end
    vectors++;
    if (spur !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mul_spurious: got spurious=%b expected 0", spur);
    end
    set_a(16'd2, 16'd9, C_AND, 1'b1);
    cyc();
    a_in_valid = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    e = pop_a();
    vectors++;
    if (n != 16 || a_obs !== e) begin
      miscompares++;
      $display("FAIL rst_mul_restart: got edges=%0d res=%h expected edges=16 res=%h", n, a_obs, e);
    end
  endtask

  task automatic test_narrow_nomul();
    logic [19:0] e;
    b_out_ready = 1'b1;
    set_b(8'h7F, 8'h01, C_ADD, 1'b0);
    cyc();
    e = pop_b();
    vectors++;
    if ({b_out_valid, b_obs} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL w8_add_ov: got %h expected %h", {b_out_valid, b_obs}, {1'b1, e});
    end
    set_b(8'h02, 8'h03, C_AND, 1'b1);
    cyc();
    e = pop_b();
    vectors++;
    if ({b_out_valid, b_obs} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL w8_mul_ignored: got %h expected %h", {b_out_valid, b_obs}, {1'b1, e});
    end
    b_in_valid = 1'b0;
    cyc();
    vectors++;
    if (b_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL w8_drain: got out_valid=%b expected 0", b_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_x = '0; a_y = '0; a_c = '0; a_mul = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_c = '0; b_mul = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_hack_b2b();
    test_backpressure();
    test_mul();
    test_reset_mid_mul();
    test_narrow_nomul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
